vernam_decipher: RTL and testbench
==================================

// Module: vernam_decipher
// PURPOSE
//  Receive-side counterpart of the Vernam encrypt path. Buffers one-time-pad key bytes
//  pushed by the key-generator PicoBlaze via write strobe. XORs each incoming ciphertext
//  byte with the oldest unused key byte and presents plaintext on a valid/ready interface.
//  Raises a level interrupt toward the key generator when key stock runs low.
// PARAMETERS
//  KEY_DEPTH  4  key FIFO entries; power of 2, >= 2
//  KEY_LOW    1  key_req asserts while key fill count <= KEY_LOW; must be < KEY_DEPTH
// PORTS
//  clk           in   1  single clock, rising edge
//  reset         in   1  asynchronous, active-high; clears all state
//  key_wr        in   1  write strobe; pushes key_data this cycle
//  key_data      in   8  key byte
//  key_req       out  1  interrupt to key generator: "send more key"
//  key_req_ack   in   1  one-cycle interrupt acknowledge from key generator
//  key_overflow  out  1  sticky: key byte dropped because FIFO was full
//  flush         in   1  synchronous: empty key FIFO, drop output byte, clear key_overflow
//  cipher_valid  in   1  ciphertext byte available
//  cipher_data   in   8  ciphertext byte
//  cipher_ready  out  1  block accepts cipher_data this cycle
//  plain_valid   out  1  plaintext byte held
//  plain_data    out  8  plaintext byte
//  plain_ready   in   1  downstream consumes plain_data this cycle
//  byte_count    out 16  plaintext bytes delivered (VERNAM_DECIPHER_CNT_EN only)
// BEHAVIOUR
//  - Reset values: key_req=0, key_overflow=0, cipher_ready=0, plain_valid=0,
//    plain_data=8'h00, byte_count=0. The key FIFO is empty after reset.
//  - Output stage FSM:
//    - EMPTY -> FULL on a cipher accept.
//    - FULL -> EMPTY on plain_ready when no accept occurs in the same cycle.
//    - FULL -> FULL on plain_ready with a same-cycle accept (back-to-back transfer).
//  - cipher_ready (combinational) = key fill > 0 && (state==EMPTY || plain_ready) && !flush.
//  - Accept = cipher_valid && cipher_ready. On accept:
//    - plain_data <= cipher_data ^ key FIFO head.
//    - The FIFO head pops.
//    - Latency is 1 cycle: plain_valid is high the cycle after the accept.
//  - plain_data stays stable while plain_valid=1 and plain_ready=0.
//  - Key push when the FIFO is full: the byte is dropped, key_overflow <= 1,
//    and FIFO contents are unchanged.
//  - Push and pop in the same cycle: both take effect and fill count is unchanged.
//    A push to a full FIFO with a same-cycle pop is accepted.
//  - FIFO pointers are log2(KEY_DEPTH)+1 bits, wrap modulo 2*KEY_DEPTH.
//    full = MSBs differ and LSBs equal.
//  - key_req is a registered flag:
//    - Set on the clock after fill <= KEY_LOW is observed.
//    - Cleared by key_req_ack; ack wins over a same-cycle set.
//    - Re-armed next cycle if fill is still <= KEY_LOW.
//    - After reset, key_req rises on the first clock (fill 0 <= KEY_LOW).
//  - flush takes priority over push, pop and accept in the same cycle:
//    - FIFO emptied, plain_valid <= 0, key_overflow <= 0.
//    - byte_count is not cleared.
//  - Asserting reset mid-transfer discards the held plaintext and all key bytes immediately.
// CONFIGURATION
//  VERNAM_DECIPHER_CNT_EN
//    - Defined: byte_count increments on each plain_valid && plain_ready and wraps 16'hFFFF -> 0.
//    - Undefined: byte_count is tied to 16'h0000 with no counter flops.
// STRUCTURE
//  - Package vernam_pkg: BYTE_W=8, typedef logic [BYTE_W-1:0] byte_t,
//    typedef enum {OUT_EMPTY, OUT_FULL} out_state_t.
//  - Sub-module vernam_key_fifo (push/pop/flush, head, fill count, full/empty).
//  - The top level holds the XOR, output FSM, interrupt flag and counter.
// TESTING
//  1. Push key 8'h5A; send cipher 8'h3C with plain_ready=1
//     -> plain_data=8'h66, plain_valid one cycle after accept.
//  2. Empty FIFO, cipher_valid=1 -> cipher_ready=0 until a key is pushed;
//     accept follows in the push+1 cycle.
//  3. Push KEY_DEPTH+1 keys (8'h01..8'h05)
//     -> key_overflow=1; the next four outputs use keys 01..04, and 05 is never used.
//  4. Hold plain_ready=0 for 5 cycles with data queued
//     -> plain_data stable, cipher_ready=0; releasing gives back-to-back transfers.
//  5. Fill FIFO to KEY_LOW=1, pulse key_req_ack in the cycle key_req would set
//     -> key_req low for 1 cycle, then re-asserts.
//  6. Assert reset while plain_valid=1 -> all outputs reset values asynchronously;
//     with CNT_EN, 65536 transfers -> byte_count wraps to 0.

Source files
------------

// File: rtl/vernam_pkg.sv
// Shared types for the Vernam decipher block.
//   BYTE_W       data path width in bits
//   byte_t       one ciphertext / key / plaintext byte
//   out_state_t  occupancy of the single-entry plaintext output stage
package vernam_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [0:0] {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/vernam_key_fifo.sv
// One-time-pad key byte FIFO.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (empties the FIFO)
//   push, push_data  write a key byte; taken when not full, or when full with a same-cycle pop
//   pop              retire the head byte (ignored when empty)
//   flush            synchronous empty; overrides push and pop
//   head             oldest unused key byte
//   fill             number of stored bytes (0..KEY_DEPTH)
//   full, empty      occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module vernam_key_fifo
  import vernam_pkg::*;
#(
  parameter int unsigned KEY_DEPTH = 4,
  parameter int unsigned FILL_W    = $clog2(KEY_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  byte_t             push_data,
  input  logic              pop,
  input  logic              flush,
  output byte_t             head,
  output logic [FILL_W-1:0] fill,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AddrW = FILL_W - 1;

  logic [FILL_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0] rd_ptr_q, rd_ptr_d;
  byte_t             mem_q [KEY_DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign fill  = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AddrW-1:0]];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vernam_decipher.sv
// Vernam receive path: XORs each ciphertext byte with the oldest unused key byte.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   key_wr, key_data                key byte write strobe from the key generator
//   key_req                         level interrupt: key stock is low
//   key_req_ack                     one-cycle acknowledge, clears key_req
//   key_overflow                    sticky: a key byte was dropped on a full FIFO
//   flush                           empty key FIFO, drop output byte, clear key_overflow
//   cipher_valid/ready/data         ciphertext input handshake
//   plain_valid/ready/data          plaintext output handshake (1-cycle latency)
//   byte_count                      delivered plaintext bytes
// Configuration: define VERNAM_DECIPHER_CNT_EN to build the byte_count counter;
// otherwise byte_count is tied to zero.
module vernam_decipher
  import vernam_pkg::*;
#(
  parameter int unsigned KEY_DEPTH = 4,
  parameter int unsigned KEY_LOW   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_wr,
  input  byte_t       key_data,
  output logic        key_req,
  input  logic        key_req_ack,
  output logic        key_overflow,
  input  logic        flush,
  input  logic        cipher_valid,
  input  byte_t       cipher_data,
  output logic        cipher_ready,
  output logic        plain_valid,
  output byte_t       plain_data,
  input  logic        plain_ready,
  output logic [15:0] byte_count
);

  localparam int unsigned FillW = $clog2(KEY_DEPTH) + 1;
  localparam logic [FillW-1:0] KeyLowFill = FillW'(KEY_LOW);

  out_state_t        state_q;
  byte_t             key_head;
  logic [FillW-1:0]  key_fill;
  logic              key_full;
  logic              key_empty;
  logic              accept;
  logic              key_drop;
  logic              key_req_q;
  logic              key_overflow_q;

  vernam_key_fifo #(
    .KEY_DEPTH (KEY_DEPTH),
    .FILL_W    (FillW)
  ) u_key_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (key_wr),
    .push_data (key_data),
    .pop       (accept),
    .flush     (flush),
    .head      (key_head),
    .fill      (key_fill),
    .full      (key_full),
    .empty     (key_empty)
  );

  assign cipher_ready = !key_empty && ((state_q == OUT_EMPTY) || plain_ready) && !flush;
  assign accept       = cipher_valid && cipher_ready;
  assign key_drop     = key_wr && key_full && !accept && !flush;

  // Output stage; plain_valid is kept as a registered copy of the FULL state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= OUT_EMPTY;
      plain_valid <= 1'b0;
      plain_data  <= '0;
    end else if (flush) begin
      state_q     <= OUT_EMPTY;
      plain_valid <= 1'b0;
    end else begin
      if (accept) plain_data <= cipher_data ^ key_head;
      unique case (state_q)
        OUT_EMPTY: begin
          if (accept) begin
            state_q     <= OUT_FULL;
            plain_valid <= 1'b1;
          end
        end
        OUT_FULL: begin
          if (!accept && plain_ready) begin
            state_q     <= OUT_EMPTY;
            plain_valid <= 1'b0;
          end
        end
        default: begin
          state_q     <= OUT_EMPTY;
          plain_valid <= 1'b0;
        end
      endcase
    end
  end

  // Ack wins over a same-cycle set; the flag re-arms next cycle while stock stays low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_req_q <= 1'b0;
    end else if (key_req_ack) begin
      key_req_q <= 1'b0;
    end else if (key_fill <= KeyLowFill) begin
      key_req_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_overflow_q <= 1'b0;
    end else if (flush) begin
      key_overflow_q <= 1'b0;
    end else if (key_drop) begin
      key_overflow_q <= 1'b1;
    end
  end

  assign key_req      = key_req_q;
  assign key_overflow = key_overflow_q;

`ifdef VERNAM_DECIPHER_CNT_EN
  logic [15:0] byte_count_q;

  // Flush does not clear the count; it wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count_q <= '0;
    end else if (plain_valid && plain_ready) begin
      byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign byte_count = byte_count_q;
`else
  assign byte_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vernam_decipher.sv
// Directed self-checking bench for vernam_decipher (KEY_DEPTH=4, KEY_LOW=1).
module tb_vernam_decipher;

  logic        clk;
  logic        reset;
  logic        key_wr;
  logic [7:0]  key_data;
  logic        key_req;
  logic        key_req_ack;
  logic        key_overflow;
  logic        flush;
  logic        cipher_valid;
  logic [7:0]  cipher_data;
  logic        cipher_ready;
  logic        plain_valid;
  logic [7:0]  plain_data;
  logic        plain_ready;
  logic [15:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;

  vernam_decipher #(
    .KEY_DEPTH (4),
    .KEY_LOW   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_wr       (key_wr),
    .key_data     (key_data),
    .key_req      (key_req),
    .key_req_ack  (key_req_ack),
    .key_overflow (key_overflow),
    .flush        (flush),
    .cipher_valid (cipher_valid),
    .cipher_data  (cipher_data),
    .cipher_ready (cipher_ready),
    .plain_valid  (plain_valid),
    .plain_data   (plain_data),
    .plain_ready  (plain_ready),
    .byte_count   (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    key_wr       = 1'b0;
    key_data     = 8'h00;
    key_req_ack  = 1'b0;
    flush        = 1'b0;
    cipher_valid = 1'b0;
    cipher_data  = 8'h00;
    plain_ready  = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    n_tests++;
    if ({key_req, key_overflow, cipher_ready, plain_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {key_req, key_overflow, cipher_ready, plain_valid});
    end
    n_tests++;
    if (plain_data !== 8'h00 || byte_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h cnt=%h want 00 0000", plain_data, byte_count);
    end
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (key_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_key_req_rise: got %b want 1", key_req);
    end
  endtask

  task automatic test_basic();
    key_wr = 1'b1; key_data = 8'h5A;
    tick();
    key_wr = 1'b0;
    cipher_valid = 1'b1; cipher_data = 8'h3C; plain_ready = 1'b1;
    #1;
    n_tests++;
    if (cipher_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: got %b want 1", cipher_ready);
    end
    tick();
    cipher_valid = 1'b0;
    n_tests++;
    if (plain_valid !== 1'b1 || plain_data !== 8'h66) begin
      n_fail++;
      $display("FAIL basic_out: got v=%b d=%h want v=1 d=66", plain_valid, plain_data);
    end
    tick();
    n_tests++;
    if (plain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got v=%b want 0", plain_valid);
    end
    n_tests++;
`ifdef VERNAM_DECIPHER_CNT_EN
    if (byte_count !== 16'h0001) begin
`else
    if (byte_count !== 16'h0000) begin
`endif
      n_fail++;
      $display("FAIL basic_count: got %h", byte_count);
    end
    idle_inputs();
  endtask

  task automatic test_empty_wait();
    cipher_valid = 1'b1; cipher_data = 8'h11; plain_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (cipher_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_ready_low[%0d]: got %b want 0", i, cipher_ready);
      end
      tick();
    end
    key_wr = 1'b1; key_data = 8'h22;
    tick();
    key_wr = 1'b0;
    #1;
    n_tests++;
    if (cipher_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_ready_after_push: got %b want 1", cipher_ready);
    end
    tick();
    cipher_valid = 1'b0;
    n_tests++;
    if (plain_valid !== 1'b1 || plain_data !== 8'h33) begin
      n_fail++;
      $display("FAIL empty_out: got v=%b d=%h want v=1 d=33", plain_valid, plain_data);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_key_req_ack();
    key_wr = 1'b1; key_data = 8'h77;
    tick();
    key_wr = 1'b0; key_req_ack = 1'b1;
    tick();
    key_req_ack = 1'b0;
    n_tests++;
    if (key_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_ack_clear: got %b want 0", key_req);
    end
    tick();
    n_tests++;
    if (key_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_rearm: got %b want 1", key_req);
    end
    key_wr = 1'b1; key_data = 8'h78;
    tick();
    key_wr = 1'b0; key_req_ack = 1'b1;
    tick();
    key_req_ack = 1'b0;
    tick();
    n_tests++;
    if (key_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_no_rearm_fill2: got %b want 0", key_req);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_tests++;
    if (key_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_after_flush: got %b want 1", key_req);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) begin
      key_wr = 1'b1; key_data = 8'(i);
      tick();
      if (i == 4) begin
        n_tests++;
        if (key_overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: got %b want 0", key_overflow);
        end
      end
    end
    key_wr = 1'b0;
    n_tests++;
    if (key_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set: got %b want 1", key_overflow);
    end
    cipher_valid = 1'b1; cipher_data = 8'h00; plain_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (plain_valid !== 1'b1 || plain_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL ovf_key[%0d]: got v=%b d=%h want v=1 d=%h", i, plain_valid, plain_data,
                 8'(i));
      end
    end
    n_tests++;
    if (cipher_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_key5_unused: cipher_ready got %b want 0", cipher_ready);
    end
    cipher_valid = 1'b0;
    tick();
    n_tests++;
    if (key_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", key_overflow);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (key_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_flush_clear: got %b want 0", key_overflow);
    end
    idle_inputs();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_keys [5];
    exp_keys = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0};
    for (int i = 0; i < 4; i++) begin
      key_wr = 1'b1; key_data = exp_keys[i];
      tick();
    end
    key_data = 8'hB0;
    cipher_valid = 1'b1; cipher_data = 8'h00; plain_ready = 1'b1;
    tick();
    key_wr = 1'b0;
    n_tests++;
    if (key_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fullpp_no_ovf: got %b want 0", key_overflow);
    end
    n_tests++;
    if (plain_data !== exp_keys[0]) begin
      n_fail++;
      $display("FAIL fullpp_out[0]: got %h want %h", plain_data, exp_keys[0]);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      n_tests++;
      if (plain_data !== exp_keys[i]) begin
        n_fail++;
        $display("FAIL fullpp_out[%0d]: got %h want %h", i, plain_data, exp_keys[i]);
      end
    end
    cipher_valid = 1'b0;
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      key_wr = 1'b1; key_data = 8'(i * 16);
      tick();
    end
    key_wr = 1'b0;
    cipher_valid = 1'b1; cipher_data = 8'h0F; plain_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (plain_valid !== 1'b1 || plain_data !== 8'h1F || cipher_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: got v=%b d=%h rdy=%b want v=1 d=1F rdy=0", i, plain_valid,
                 plain_data, cipher_ready);
      end
      tick();
    end
    plain_ready = 1'b1;
    tick();
    n_tests++;
    if (plain_valid !== 1'b1 || plain_data !== 8'h2F) begin
      n_fail++;
      $display("FAIL b2b_1: got v=%b d=%h want v=1 d=2F", plain_valid, plain_data);
    end
    tick();
    n_tests++;
    if (plain_valid !== 1'b1 || plain_data !== 8'h3F || cipher_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_2: got v=%b d=%h rdy=%b want v=1 d=3F rdy=0", plain_valid, plain_data,
               cipher_ready);
    end
    cipher_valid = 1'b0;
    tick();
    n_tests++;
    if (plain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %b want 0", plain_valid);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      key_wr = 1'b1; key_data = 8'h44 + 8'(i);
      tick();
    end
    key_wr = 1'b0;
    cipher_valid = 1'b1; cipher_data = 8'h00; plain_ready = 1'b0;
    tick();
    n_tests++;
    if (plain_valid !== 1'b1 || plain_data !== 8'h44 || key_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: got v=%b d=%h ovf=%b want 1 44 1", plain_valid, plain_data,
               key_overflow);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({key_req, key_overflow, cipher_ready, plain_valid} !== 4'b0000 ||
        plain_data !== 8'h00 || byte_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL rstmid_async: got flags=%b d=%h cnt=%h want 0000 00 0000",
               {key_req, key_overflow, cipher_ready, plain_valid}, plain_data, byte_count);
    end
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (cipher_ready !== 1'b0 || plain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_keys_gone: got rdy=%b v=%b want 0 0", cipher_ready, plain_valid);
    end
    idle_inputs();
  endtask

`ifdef VERNAM_DECIPHER_CNT_EN
  task automatic test_count_wrap();
    // Edge 1 only pushes; edge 2 accepts; every edge from 3 on delivers one byte.
    key_wr = 1'b1; key_data = 8'h01;
    cipher_valid = 1'b1; cipher_data = 8'h00; plain_ready = 1'b1;
    repeat (65537) tick();
    n_tests++;
    if (byte_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL cnt_max: got %h want FFFF", byte_count);
    end
    tick();
    n_tests++;
    if (byte_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL cnt_wrap: got %h want 0000", byte_count);
    end
    key_wr = 1'b0; cipher_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_tests++;
    if (byte_count !== 16'h0001 || plain_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_flush_keeps: got cnt=%h v=%b want 0001 0", byte_count, plain_valid);
    end
    idle_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty_wait();
    test_key_req_ack();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
`ifdef VERNAM_DECIPHER_CNT_EN
    test_count_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
